// File: rtl/repl_req_arbiter.sv
// Round-robin arbiter sharing one DRRIP replacement engine between NUM_REQ lookup ports.
// Optional saturating perf counters are compiled in when REPL_ARB_PERF_EN is defined.
module repl_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int SET_INDEX_WIDTH = 7,
  parameter int WAY_BITS        = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*SET_INDEX_WIDTH-1:0] req_set,
  input  logic [NUM_REQ*WAY_BITS-1:0]        req_way,
  input  logic [NUM_REQ-1:0]                 req_hit,
  output logic                               resp_valid,
  output logic [ID_W-1:0]                    resp_id,
  output logic [WAY_BITS-1:0]                resp_way,
  output logic                               resp_err,
  output logic                               eng_valid,
  output logic                               eng_hit,
  output logic                               eng_miss,
  output logic [SET_INDEX_WIDTH-1:0]         eng_set_index,
  output logic [WAY_BITS-1:0]                eng_access_way,
  input  logic [WAY_BITS-1:0]                eng_victim_way,
`ifdef REPL_ARB_PERF_EN
  output logic [15:0]                        perf_hits,
  output logic [15:0]                        perf_misses,
  output logic [15:0]                        perf_timeouts,
`endif
  input  logic                               eng_victim_ready
);

  typedef enum logic [1:0] {IDLE, HIT_ISSUE, MISS_WAIT, RESP} state_t;

  localparam logic [7:0]    TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W:0] NUM_REQ_W    = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);

  state_t                     state_q, state_d;
  logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]            id_q, id_d;
  logic [SET_INDEX_WIDTH-1:0] set_q, set_d;
  logic [WAY_BITS-1:0]        way_q, way_d;
  logic [WAY_BITS-1:0]        victim_q, victim_d;
  logic                       err_q, err_d;
  logic [7:0]                 cnt_q, cnt_d;

  logic                       grant_found;
  logic [ID_W-1:0]            grant_id;

  // Scan requesters starting at rr_ptr_q and pick the first one asserting valid.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [ID_W:0] sum;
      logic [ID_W-1:0] idx;
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      idx = (sum >= NUM_REQ_W) ? ID_W'(sum - NUM_REQ_W) : ID_W'(sum);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign req_ready = (state_q == IDLE && grant_found) ? (NUM_REQ'(1) << grant_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      set_q    <= '0;
      way_q    <= '0;
      victim_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      set_q    <= set_d;
      way_q    <= way_d;
      victim_q <= victim_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // In MISS_WAIT the engine strobes drop in the same cycle ready pulses, so a miss
  // can never trigger a second victim search or PSEL update.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    id_d           = id_q;
    set_d          = set_q;
    way_d          = way_q;
    victim_d       = victim_q;
    err_d          = err_q;
    cnt_d          = cnt_q;
    eng_valid      = 1'b0;
    eng_hit        = 1'b0;
    eng_miss       = 1'b0;
    eng_set_index  = set_q;
    eng_access_way = way_q;
    resp_valid     = 1'b0;
    resp_id        = '0;
    resp_way       = '0;
    resp_err       = 1'b0;
    case (state_q)
      IDLE: begin
        eng_set_index  = '0;
        eng_access_way = '0;
        if (grant_found) begin
          id_d     = grant_id;
          set_d    = req_set[int'(grant_id)*SET_INDEX_WIDTH +: SET_INDEX_WIDTH];
          way_d    = req_way[int'(grant_id)*WAY_BITS +: WAY_BITS];
          rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
          cnt_d    = '0;
          state_d  = req_hit[grant_id] ? HIT_ISSUE : MISS_WAIT;
        end
      end
      HIT_ISSUE: begin
        eng_valid = 1'b1;
        eng_hit   = 1'b1;
        state_d   = IDLE;
      end
      MISS_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (eng_victim_ready) begin
          victim_d = eng_victim_way;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          victim_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          eng_valid = 1'b1;
          eng_miss  = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_id    = id_q;
        resp_way   = victim_q;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef REPL_ARB_PERF_EN
  logic [15:0] perf_hits_q, perf_misses_q, perf_timeouts_q;
  logic        acc_hit, acc_miss, abort_to;

  assign acc_hit  = (state_q == IDLE) && grant_found && req_hit[grant_id];
  assign acc_miss = (state_q == IDLE) && grant_found && !req_hit[grant_id];
  assign abort_to = (state_q == MISS_WAIT) && !eng_victim_ready && (cnt_q == TIMEOUT_LAST);

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits_q     <= '0;
      perf_misses_q   <= '0;
      perf_timeouts_q <= '0;
    end else begin
      if (acc_hit && perf_hits_q != 16'hFFFF)
        perf_hits_q <= perf_hits_q + 16'd1;
      if (acc_miss && perf_misses_q != 16'hFFFF)
        perf_misses_q <= perf_misses_q + 16'd1;
      if (abort_to && perf_timeouts_q != 16'hFFFF)
        perf_timeouts_q <= perf_timeouts_q + 16'd1;
    end
  end

  assign perf_hits     = perf_hits_q;
  assign perf_misses   = perf_misses_q;
  assign perf_timeouts = perf_timeouts_q;
`endif

endmodule
